dll_tx_scheduler: RTL

Transmit-side data-link scheduler that sequences the replay buffer.
- Admits new TLPs from the transaction layer and assigns sequence numbers.
- Tracks outstanding (unacknowledged) TLPs; converts incoming ACK/NAK DLLPs into purge commands for the replay buffer.
- Launches replays on NAK or replay-timer expiry; requests link retrain on replay-count rollover.
- Sits between the transaction layer, the DLLP receive path and the replay-buffer FSM.

---
 rtl/dll_pkg.sv | 25 ++
 rtl/dll_tx_scheduler_replay_timer.sv | 31 +++
 rtl/dll_tx_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dll_pkg.sv
// Shared types and helpers for the data-link transmit scheduler.
package dll_pkg;

  localparam int DEFAULT_SEQ_W = 12;

  localparam logic [1:0] ACKNAK_ACK = 2'b01;
  localparam logic [1:0] ACKNAK_NAK = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACK     = 3'd1,
    ST_NAK     = 3'd2,
    ST_RETRAIN = 3'd3,
    ST_REPLAY  = 3'd4
  } state_e;

  // Modular distance a-b folded into a w-bit sequence space.
  function automatic logic [31:0] seq_dist(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/dll_tx_scheduler_replay_timer.sv
// Replay timer: counts while enabled, holds otherwise, saturates and flags expiry at TIMER_MAX.
module replay_timer #(
  parameter int TIMER_MAX = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expire
);

  localparam int TW = $clog2(TIMER_MAX + 1);

  logic [TW-1:0] count_r;

  // Timer count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (count_en && (count_r != TW'(TIMER_MAX))) begin
      count_r <= count_r + TW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == TW'(TIMER_MAX));

endmodule

// File: rtl/dll_tx_scheduler.sv
// Transmit-side DLL scheduler: sequence numbering, ACK/NAK purge, replay and retrain control.
// Define REPLAY_TIMER_EN to include the replay timer and timeout-initiated replays.
module dll_tx_scheduler
  import dll_pkg::*;
#(
  parameter int SEQ_W        = DEFAULT_SEQ_W,
  parameter int MAX_OUT      = 64,
  parameter int TIMER_MAX    = 1000,
  parameter int REPLAY_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tlp_req,
  output logic             tlp_gnt,
  output logic [SEQ_W-1:0] tx_seq,
  input  logic             dllp_vld,
  input  logic [1:0]       dllp_type,
  input  logic [SEQ_W-1:0] dllp_seq,
  input  logic             busy_n,
  output logic             buf_we,
  output logic [1:0]       buf_acknak,
  output logic [SEQ_W-1:0] buf_ack_seq,
  output logic             rep_req,
  output logic [SEQ_W-1:0] num_to_rep,
  input  logic             rep_done,
  output logic             retrain,
  output logic [SEQ_W-1:0] outstanding
);

  localparam int RN_W = $clog2(REPLAY_LIMIT + 1);

  state_e           state_r;
  logic [SEQ_W-1:0] next_seq_r, ackd_seq_r, pend_seq_r;
  logic             pend_vld_r;
  logic [RN_W-1:0]  replay_num_r;

  logic [SEQ_W-1:0] out_s, d_s, pend_d_s, nak_rep_s;
  logic             dv_s, pend_ok_s, is_ack_s, is_nak_s, gnt_ok_s;
  logic             timer_clr_s, timer_en_s, expire_s;

  assign out_s     = SEQ_W'(seq_dist(32'(next_seq_r), 32'(ackd_seq_r), SEQ_W)) - SEQ_W'(1);
  assign d_s       = SEQ_W'(seq_dist(32'(dllp_seq), 32'(ackd_seq_r), SEQ_W));
  assign pend_d_s  = SEQ_W'(seq_dist(32'(pend_seq_r), 32'(ackd_seq_r), SEQ_W));
  assign nak_rep_s = SEQ_W'(seq_dist(32'(next_seq_r - SEQ_W'(1)), 32'(dllp_seq), SEQ_W));
  assign dv_s      = (d_s != '0) && (d_s <= out_s);
  assign pend_ok_s = (pend_d_s != '0) && (pend_d_s <= out_s);
  assign is_ack_s  = dllp_vld && (dllp_type == ACKNAK_ACK);
  assign is_nak_s  = dllp_vld && (dllp_type == ACKNAK_NAK);
  assign gnt_ok_s  = tlp_req && busy_n && (out_s < SEQ_W'(MAX_OUT));

  // Forward progress (any purge) or a finished replay restarts the timeout window.
  assign timer_clr_s = ((state_r == ST_IDLE) && (is_ack_s || is_nak_s) && dv_s)
                     || ((state_r == ST_IDLE) && !dllp_vld && pend_vld_r && pend_ok_s)
                     || ((state_r == ST_REPLAY) && rep_req && rep_done);
  assign timer_en_s  = (state_r == ST_IDLE) && (out_s != '0);

`ifdef REPLAY_TIMER_EN
  replay_timer #(.TIMER_MAX(TIMER_MAX)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .count_en (timer_en_s),
    .clear    (timer_clr_s),
    .expire   (expire_s)
  );
`else
  logic [33:0] unused_timer_s;
  assign unused_timer_s = {32'(TIMER_MAX), timer_en_s, timer_clr_s};
  assign expire_s       = 1'b0;
`endif

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      next_seq_r   <= '0;
      ackd_seq_r   <= '1;
      pend_seq_r   <= '0;
      pend_vld_r   <= 1'b0;
      replay_num_r <= '0;
      tlp_gnt      <= 1'b0;
      buf_we       <= 1'b0;
      tx_seq       <= '0;
      buf_acknak   <= 2'b00;
      buf_ack_seq  <= '0;
      rep_req      <= 1'b0;
      num_to_rep   <= '0;
      retrain      <= 1'b0;
    end else begin
      tlp_gnt    <= 1'b0;
      buf_we     <= 1'b0;
      buf_acknak <= 2'b00;
      retrain    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (dllp_vld) begin
            if (is_ack_s && dv_s) begin
              ackd_seq_r   <= dllp_seq;
              buf_acknak   <= ACKNAK_ACK;
              buf_ack_seq  <= dllp_seq;
              replay_num_r <= '0;
              state_r      <= ST_ACK;
            end else if (is_nak_s && (dv_s || (d_s == '0))) begin
              if (dv_s) begin
                ackd_seq_r   <= dllp_seq;
                buf_acknak   <= ACKNAK_NAK;
                buf_ack_seq  <= dllp_seq;
                replay_num_r <= '0;
              end
              num_to_rep <= nak_rep_s;
              state_r    <= ST_NAK;
            end
          end else if (pend_vld_r) begin
            // ACK deferred from the last replay; re-validated in case it went stale
            pend_vld_r <= 1'b0;
            if (pend_ok_s) begin
              ackd_seq_r   <= pend_seq_r;
              buf_acknak   <= ACKNAK_ACK;
              buf_ack_seq  <= pend_seq_r;
              replay_num_r <= '0;
              state_r      <= ST_ACK;
            end
          end else if (expire_s && (out_s != '0)) begin
            num_to_rep <= out_s;
            state_r    <= ST_NAK;
          end else if (gnt_ok_s) begin
            tlp_gnt    <= 1'b1;
            buf_we     <= 1'b1;
            tx_seq     <= next_seq_r;
            next_seq_r <= next_seq_r + SEQ_W'(1);
          end
        end
        ST_ACK: state_r <= ST_IDLE;
        ST_NAK: begin
          // Replay decision, shared by NAK and timeout
          if (num_to_rep == '0) begin
            state_r <= ST_IDLE;
          end else if (replay_num_r == RN_W'(REPLAY_LIMIT)) begin
            retrain      <= 1'b1;
            replay_num_r <= '0;
            state_r      <= ST_RETRAIN;
          end else begin
            replay_num_r <= replay_num_r + RN_W'(1);
            state_r      <= ST_REPLAY;
          end
        end
        ST_RETRAIN: state_r <= ST_REPLAY;
        ST_REPLAY: begin
          if (!rep_req) begin
            rep_req <= busy_n;
          end else if (rep_done) begin
            rep_req <= 1'b0;
            state_r <= ST_IDLE;
          end
          if (is_ack_s && dv_s) begin
            pend_vld_r <= 1'b1;
            pend_seq_r <= dllp_seq;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Outstanding count output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      outstanding <= out_s;
    end
  end

endmodule
